// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
// Build option MUL_SIGNED_EN selects two's-complement (Booth) operation.
package mul_pkg;

  localparam int MUL_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Step counter width for a given operand width.
  function automatic int mul_cnt_w(input int width);
    return $clog2(width);
  endfunction

  localparam int MUL_CNT_W_DEF = mul_cnt_w(MUL_WIDTH_DEF);

endpackage

// File: rtl/mul_step.sv
// One multiply iteration (combinational, zero latency, no flow control).
// MUL_SIGNED_EN: radix-2 Booth step with history bit; otherwise unsigned shift-add.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
`ifdef MUL_SIGNED_EN
  input  logic               hist,
  output logic               hist_nxt,
`endif
  output logic [2*WIDTH-1:0] acc_nxt
);

`ifdef MUL_SIGNED_EN
  logic [WIDTH:0] upper;
  logic [WIDTH:0] mext;
  logic [WIDTH:0] upper_nxt;

  // W+1-bit upper arithmetic keeps every partial sum exact, including -2^(W-1) squared.
  always_comb begin
    upper = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
    mext  = {mcand[WIDTH-1], mcand};
    unique case ({acc[0], hist})
      2'b10:   upper_nxt = upper - mext;
      2'b01:   upper_nxt = upper + mext;
      default: upper_nxt = upper;
    endcase
    acc_nxt  = {upper_nxt, acc[WIDTH-1:1]};
    hist_nxt = acc[0];
  end
`else
  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/mul_seq32.sv
// Iterative multiplier: start -> product after WIDTH steps, one-cycle done strobe.
// No backpressure: start is ignored while busy; MUL_SIGNED_EN selects signed mode.
module mul_seq32
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = mul_cnt_w(WIDTH);

  mul_state_t         state;
  mul_state_t         state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mcand;
  logic               accept;
  logic               last;
`ifdef MUL_SIGNED_EN
  logic               hist;
  logic               hist_nxt;
`endif

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
`ifdef MUL_SIGNED_EN
    .hist     (hist),
    .hist_nxt (hist_nxt),
`endif
    .acc_nxt  (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CW'(WIDTH - 1));
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      product <= '0;
`ifdef MUL_SIGNED_EN
      hist    <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      acc     <= {{WIDTH{1'b0}}, b};
      mcand   <= a;
`ifdef MUL_SIGNED_EN
      hist    <= 1'b0;
`endif
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      acc <= acc_nxt;
`ifdef MUL_SIGNED_EN
      hist <= hist_nxt;
`endif
      // Result register only moves on the edge that enters DONE.
      if (last) product <= acc_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq32.sv
// Directed self-checking bench for mul_seq32 (either build of MUL_SIGNED_EN).
module tb_mul_seq32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_vec = 0;
  int n_err = 0;

  mul_seq32 #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered right after a negedge; leaves at the negedge following the accepting edge.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    a = va;
    b = vb;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Counts busy cycles until done is seen, bounded.
  task automatic wait_done(output int nb, output bit seen);
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [63:0] exp);
    int nb;
    bit seen;
    issue(va, vb);
    wait_done(nb, seen);
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(nb), 64'd32);
    chk({tag, "_prod"}, product, exp);
    @(negedge clk);
  endtask

  initial begin
    int  nb;
    int  nb2;
    int  ndone;
    bit  seen;

    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", product, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 3 x 5
    issue(32'd3, 32'd5);
    chk("p35_busy", 64'(busy), 64'd1);
    wait_done(nb, seen);
    chk("p35_done", 64'(seen), 64'd1);
    chk("p35_lat", 64'(nb), 64'd32);
    chk("p35_prod", product, 64'd15);
    @(negedge clk);
    chk("p35_strobe", 64'(done), 64'd0);
    chk("p35_idle", 64'(busy), 64'd0);
    chk("p35_hold", product, 64'd15);

`ifdef MUL_SIGNED_EN
    run_vec("sm1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_vec("smin",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_vec("s7m3",  32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
`else
    run_vec("umax",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_vec("umin",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_vec("u7m3",  32'd7,         32'hFFFF_FFFD, 64'h0000_0006_FFFF_FFEB);
`endif

    // start during RUN must be ignored
    issue(32'd2, 32'd4);
    repeat (9) @(negedge clk);
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, seen);
    chk("ign_done", 64'(seen), 64'd1);
    chk("ign_lat", 64'(nb + 10), 64'd32);
    chk("ign_prod", product, 64'd8);
    @(negedge clk);

    // back-to-back with start held high
    start = 1'b1;
    a = 32'd6;
    b = 32'd7;
    @(negedge clk);
    a = 32'd10;
    b = 32'd10;
    wait_done(nb, seen);
    chk("b2b1_done", 64'(seen), 64'd1);
    chk("b2b1_busy", 64'(nb), 64'd32);
    chk("b2b1_bdone", 64'(busy), 64'd0);
    chk("b2b1_prod", product, 64'd42);
    @(negedge clk);
    wait_done(nb2, seen);
    start = 1'b0;
    chk("b2b2_done", 64'(seen), 64'd1);
    chk("b2b_gap", 64'(nb2 + 1), 64'd33);
    chk("b2b2_bdone", 64'(busy), 64'd0);
    chk("b2b2_prod", product, 64'd100);
    @(negedge clk);
    chk("b2b_stop", 64'(busy), 64'd0);

    // asynchronous reset in the middle of RUN
    issue(32'h0000_FFFF, 32'h0000_FFFF);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_prod", product, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_nodone", 64'(ndone), 64'd0);
    run_vec("arst_new", 32'd11, 32'd13, 64'd143);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
